// File: rtl/mem_frame_reader_pkg.sv
// rtl/mem_frame_reader_pkg.sv - shared constants, types and round-robin helper for the frame reader
package mem_frame_reader_pkg;

    localparam int PORT_WIDTH = 4;
    localparam int ADDR_W     = 10;
    localparam int LEN_W      = 9;

    localparam logic [1:0] INFO_MID    = 2'b00;
    localparam logic [1:0] INFO_START  = 2'b01;
    localparam logic [1:0] INFO_END    = 2'b10;
    localparam logic [1:0] INFO_SINGLE = 2'b11;

    localparam int FIFO_W = 36;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_READ,
        ST_DRAIN
    } state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  info;
        logic [1:0]  extra;
    } fifo_word_t;

    // First requesting port after 'last' in cyclic order 0,1,2; lowest k wins.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
        int idx;
        rr_pick = last;
        for (int k = 3; k >= 1; k--) begin
            idx = (int'(last) + k) % 3;
            if (req[idx]) rr_pick = 2'(idx);
        end
    endfunction

endpackage

// File: rtl/mem_frame_reader_if.sv
// rtl/mem_frame_reader_if.sv - request, bank and egress signal bundle of the frame reader
interface mem_frame_reader_if #(
    parameter int pPORT_WIDTH = 4,
    parameter int pADDR_W     = 10,
    parameter int pLEN_W      = 9
);
    localparam int PN_W = $clog2(pPORT_WIDTH);

    logic [2:0]         i_req;
    logic [pADDR_W-1:0] i_addr_port1;
    logic [pADDR_W-1:0] i_addr_port2;
    logic [pADDR_W-1:0] i_addr_port3;
    logic [pLEN_W-1:0]  i_len_port1;
    logic [pLEN_W-1:0]  i_len_port2;
    logic [pLEN_W-1:0]  i_len_port3;
    logic [2:0]         o_ack;

    logic               o_mem_rd_en;
    logic [pADDR_W-1:0] o_mem_addr;
    logic [31:0]        i_mem_data;
    logic [1:0]         i_mem_info;
    logic [1:0]         i_mem_extra;

    logic [31:0]        o_data;
    logic [1:0]         o_info_port;
    logic [1:0]         o_extra_byte;
    logic [2:0]         o_valid;
    logic [2:0]         i_port_ready;
    logic [PN_W-1:0]    o_port_num;
    logic               o_done;
    logic               o_err;

    modport slave (
        input  i_req, i_addr_port1, i_addr_port2, i_addr_port3,
        input  i_len_port1, i_len_port2, i_len_port3,
        input  i_mem_data, i_mem_info, i_mem_extra, i_port_ready,
        output o_ack, o_mem_rd_en, o_mem_addr, o_data, o_info_port, o_extra_byte,
        output o_valid, o_port_num, o_done, o_err
    );

    modport master (
        output i_req, i_addr_port1, i_addr_port2, i_addr_port3,
        output i_len_port1, i_len_port2, i_len_port3,
        output i_mem_data, i_mem_info, i_mem_extra, i_port_ready,
        input  o_ack, o_mem_rd_en, o_mem_addr, o_data, o_info_port, o_extra_byte,
        input  o_valid, o_port_num, o_done, o_err
    );

endinterface

// File: rtl/mem_frame_reader_fifo.sv
// rtl/mem_frame_reader_fifo.sv - 3-entry return-word FIFO (mem_rd_fifo3) with occupancy count
module mem_rd_fifo3 #(
    parameter int W = 36
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] mem_q [3];
    logic [1:0]   wr_q, rd_q, cnt_q;
    logic         do_push, do_pop;

    assign do_pop  = pop_i && (cnt_q != 2'd0);
    assign do_push = push_i && ((cnt_q != 2'd3) || do_pop);

    // Empty head reads as zero so the egress outputs are clean between frames.
    assign rdata_o = (cnt_q != 2'd0) ? mem_q[rd_q] : '0;
    assign count_o = cnt_q;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= 2'd0;
            rd_q  <= 2'd0;
            cnt_q <= 2'd0;
        end else begin
            if (do_push) wr_q <= (wr_q == 2'd2) ? 2'd0 : wr_q + 2'd1;
            if (do_pop)  rd_q <= (rd_q == 2'd2) ? 2'd0 : rd_q + 2'd1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 2'd1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 2'd1;
        end
    end

endmodule

// File: rtl/mem_frame_reader.sv
// rtl/mem_frame_reader.sv - round-robin frame reader from a word bank to three egress ports
module mem_frame_reader
    import mem_frame_reader_pkg::*;
#(
    parameter int pPORT_WIDTH = PORT_WIDTH,
    parameter int pADDR_W     = ADDR_W,
    parameter int pLEN_W      = LEN_W
) (
    input  logic i_clk,
    input  logic i_reset,
    mem_frame_reader_if.slave bus
);
    localparam int PN_W = $clog2(pPORT_WIDTH);

    state_t             state_q;
    logic [1:0]         rr_last_q, port_q;
    logic [pADDR_W-1:0] addr_q;
    logic [pLEN_W-1:0]  rem_q, xfer_left_q;
    logic               first_q, inflight_q;
    logic [2:0]         ack_q;
    logic               done_q, err_q;

    logic [1:0]         pick;
    logic [pADDR_W-1:0] sel_addr;
    logic [pLEN_W-1:0]  sel_len;
    logic [2:0]         port_oh;
    logic               rd_en, pop;
    logic [1:0]         fifo_count;
    logic [FIFO_W-1:0]  fifo_rdata;
    fifo_word_t         head;

    mem_rd_fifo3 #(.W(FIFO_W)) u_fifo (
        .clk     (i_clk),
        .reset   (i_reset),
        .push_i  (inflight_q),
        .wdata_i ({bus.i_mem_data, bus.i_mem_info, bus.i_mem_extra}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count)
    );

    assign head    = fifo_word_t'(fifo_rdata);
    assign pick    = rr_pick(bus.i_req, rr_last_q);
    assign port_oh = 3'b001 << port_q;

    // Stored words plus the one in flight must leave room; a same-cycle pop is not credited.
    assign rd_en = (state_q == ST_READ) &&
                   (({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'd3);
    assign pop   = (fifo_count != 2'd0) && ((bus.i_port_ready & port_oh) != 3'b000);

    always_comb begin
        sel_addr = bus.i_addr_port1;
        sel_len  = bus.i_len_port1;
        case (pick)
            2'd1: begin sel_addr = bus.i_addr_port2; sel_len = bus.i_len_port2; end
            2'd2: begin sel_addr = bus.i_addr_port3; sel_len = bus.i_len_port3; end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            rr_last_q   <= 2'd2;
            port_q      <= 2'd0;
            addr_q      <= '0;
            rem_q       <= '0;
            xfer_left_q <= '0;
            first_q     <= 1'b0;
            inflight_q  <= 1'b0;
            ack_q       <= 3'b000;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ack_q      <= 3'b000;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            inflight_q <= rd_en;
            if (rd_en) begin
                addr_q <= addr_q + 1'b1;
                rem_q  <= rem_q - 1'b1;
            end
            if (pop) begin
                first_q     <= 1'b0;
                xfer_left_q <= xfer_left_q - 1'b1;
                if ((first_q && !head.info[0]) ||
                    (xfer_left_q == pLEN_W'(1) && !head.info[1]))
                    err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_req != 3'b000) begin
                        port_q      <= pick;
                        rr_last_q   <= pick;
                        addr_q      <= sel_addr;
                        rem_q       <= sel_len;
                        xfer_left_q <= sel_len;
                        first_q     <= 1'b1;
                        ack_q       <= 3'b001 << pick;
                        state_q     <= ST_GRANT;
                    end
                end
                ST_GRANT: state_q <= (rem_q == '0) ? ST_DRAIN : ST_READ;
                ST_READ: begin
                    if (rd_en && rem_q == pLEN_W'(1)) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (fifo_count == 2'd0 && !inflight_q) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_ack        = ack_q;
    assign bus.o_mem_rd_en  = rd_en;
    assign bus.o_mem_addr   = addr_q;
    assign bus.o_valid      = (fifo_count != 2'd0) ? port_oh : 3'b000;
    assign bus.o_data       = head.data;
    assign bus.o_info_port  = head.info;
    assign bus.o_extra_byte = head.extra;
    assign bus.o_port_num   = PN_W'(port_q);
    assign bus.o_done       = done_q;
    assign bus.o_err        = err_q;

endmodule
